// File: rtl/counter_0to7_non_recycled.sv
// Three-bit up-counter that saturates at 7 and never wraps; only reset restarts it.
// The next-state logic is built from explicit toggle gates, and the flops have an asynchronous clear.
module counter_0to7_non_recycled (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] count
);

  logic [2:0] r_q;
  logic       w_sat;
  logic [2:0] w_t;
  logic [2:0] w_d;

  // A bit toggles when every lower bit is 1, unless the counter is already at 7.
  assign w_sat  = r_q[2] & r_q[1] & r_q[0];
  assign w_t[0] = ~w_sat;
  assign w_t[1] = r_q[0] & ~w_sat;
  assign w_t[2] = r_q[1] & r_q[0] & ~w_sat;
  assign w_d    = r_q ^ w_t;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 3'd0;
    end else begin
      r_q <= w_d;
    end
  end

  assign count = r_q;

endmodule

// File: tb/tb_counter_0to7_non_recycled.sv
// Bench for counter_0to7_non_recycled: directed scenarios from the test plan, followed by random reset pulses.
// A reference model counts the edges since reset release and returns min(N, 7).
module tb_counter_0to7_non_recycled;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] count;

  logic [2:0] exp_q[$];
  logic [2:0] exp_v;
  int         n_vec = 0;
  int         n_err = 0;
  int         edges_since = 0;

  counter_0to7_non_recycled dut (
    .clk   (clk),
    .reset (reset),
    .count (count)
  );

  // The clock rises at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [2:0] model_count(input int n);
    int s;
    s = (n >= 7) ? 7 : n;
    return s[2:0];
  endfunction

  // Advance one edge and sample 1 time unit later; the model follows the reset level seen before the edge.
  task automatic tick();
    logic r_before;
    r_before = reset;
    @(posedge clk);
    #1;
    if (r_before) edges_since = 0;
    else          edges_since = edges_since + 1;
    exp_q.push_back(model_count(edges_since));
  endtask

  // Assert or release reset between edges.
  task automatic drv_reset(input logic v);
    reset = v;
    if (v) begin
      edges_since = 0;
      #1;
      exp_q.push_back(3'd0);
    end
  endtask

  task automatic test_reset();
    #10 reset = 1'b1;
    edges_since = 0;
    #1;
    exp_v = 3'd0; n_vec++;
    if (count !== exp_v) begin $display("FAIL reset_assert_t11 count=%0d exp=%0d", count, exp_v); n_err++; end
    tick(); exp_v = exp_q.pop_front(); n_vec++;
    if (count !== exp_v) begin $display("FAIL reset_edge15 count=%0d exp=%0d", count, exp_v); n_err++; end
    #4 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_v = exp_q.pop_front(); n_vec++;
      if (count !== exp_v) begin $display("FAIL poweron_edge%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
    end
  endtask

  task automatic test_full_count();
    drv_reset(1'b1); exp_v = exp_q.pop_front(); n_vec++;
    if (count !== exp_v) begin $display("FAIL full_reset count=%0d exp=%0d", count, exp_v); n_err++; end
    drv_reset(1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick(); exp_v = exp_q.pop_front(); n_vec++;
      if (count !== exp_v) begin $display("FAIL full_count_edge%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
    end
  endtask

  task automatic test_async_mid();
    drv_reset(1'b1); void'(exp_q.pop_front());
    drv_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); void'(exp_q.pop_front());
    end
    exp_v = 3'd4; n_vec++;
    if (count !== exp_v) begin $display("FAIL async_pre count=%0d exp=%0d", count, exp_v); n_err++; end
    #2;
    drv_reset(1'b1); exp_v = exp_q.pop_front(); n_vec++;
    if (count !== exp_v) begin $display("FAIL async_mid count=%0d exp=%0d", count, exp_v); n_err++; end
    drv_reset(1'b0);
    tick(); exp_v = exp_q.pop_front(); n_vec++;
    if (count !== exp_v) begin $display("FAIL async_after count=%0d exp=%0d", count, exp_v); n_err++; end
  endtask

  task automatic test_reset_at_sat();
    for (int i = 0; i < 6; i++) begin
      tick(); void'(exp_q.pop_front());
    end
    exp_v = 3'd7; n_vec++;
    if (count !== exp_v) begin $display("FAIL sat_reach count=%0d exp=%0d", count, exp_v); n_err++; end
    drv_reset(1'b1); exp_v = exp_q.pop_front(); n_vec++;
    if (count !== exp_v) begin $display("FAIL sat_reset count=%0d exp=%0d", count, exp_v); n_err++; end
    for (int i = 0; i < 2; i++) begin
      tick(); exp_v = exp_q.pop_front(); n_vec++;
      if (count !== exp_v) begin $display("FAIL sat_held%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
    end
    drv_reset(1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); exp_v = exp_q.pop_front(); n_vec++;
      if (count !== exp_v) begin $display("FAIL sat_release%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
    end
  endtask

  task automatic test_reset_held();
    drv_reset(1'b1); void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      tick(); exp_v = exp_q.pop_front(); n_vec++;
      if (count !== exp_v) begin $display("FAIL held_edge%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
    end
  endtask

  // Reset is still high from test_reset_held. It is released in the NBA region of the edge, so the flop sees it high.
  task automatic test_release_on_edge();
    @(posedge clk);
    reset <= 1'b0;
    #1;
    edges_since = 0;
    exp_v = 3'd0; n_vec++;
    if (count !== exp_v) begin $display("FAIL edge_release_same count=%0d exp=%0d", count, exp_v); n_err++; end
    tick(); exp_v = exp_q.pop_front(); n_vec++;
    if (count !== exp_v) begin $display("FAIL edge_release_next count=%0d exp=%0d", count, exp_v); n_err++; end
  endtask

  task automatic test_random();
    int hold;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        #($urandom_range(1, 6));
        drv_reset(1'b1); exp_v = exp_q.pop_front(); n_vec++;
        if (count !== exp_v) begin $display("FAIL rand_async%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
          tick(); exp_v = exp_q.pop_front(); n_vec++;
          if (count !== exp_v) begin $display("FAIL rand_hold%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
        end
        drv_reset(1'b0);
      end
      tick(); exp_v = exp_q.pop_front(); n_vec++;
      if (count !== exp_v) begin $display("FAIL rand_edge%0d count=%0d exp=%0d", i, count, exp_v); n_err++; end
    end
  endtask

  initial begin
    test_reset();
    test_full_count();
    test_async_mid();
    test_reset_at_sat();
    test_reset_held();
    test_release_on_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
